// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Operation encoding matches the decoder's operation64 select.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } mdu_state_t;

    localparam logic MD_MULT = 1'b1;
    localparam logic MD_DIV  = 1'b0;

    // Quotient bit pattern written to LO on divide by zero (all ones).
    localparam logic MD_DIV0_QBIT = 1'b1;

endpackage

// File: rtl/mdu_step.sv
// One shift-add (MULT) or restoring-subtract (DIV) iteration.
// Purely combinational; the quotient bit is merged into bit 0 by the caller.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    // MULT: add multiplicand on LSB, shift right. DIV: shift left, trial subtract.
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + {1'b0, opnd_i & {WIDTH{acc_i[0]}}};
        sh     = {acc_i[2*WIDTH-2:0], 1'b0};
        trial  = {acc_i[2*WIDTH-1], sh[2*WIDTH-1:WIDTH]};
        diff   = trial - {1'b0, opnd_i};
        acc_o  = sh;
        qbit_o = 1'b0;
        if (op_i == MD_MULT) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_o  = {diff[WIDTH-1:0], sh[WIDTH-1:0]};
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV unit owning the HI/LO registers.
// WIDTH iterations on magnitudes, then one cycle of sign correction.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             operation64,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q;
    logic [CNTW-1:0]    cnt_q;
    logic               op_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] step_acc;
    logic               qbit;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    // 0x80000000 maps to itself, which is 2^31 read as unsigned.
    assign abs_a = srca[WIDTH-1] ? (~srca + 1'b1) : srca;
    assign abs_b = srcb[WIDTH-1] ? (~srcb + 1'b1) : srcb;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .qbit_o (qbit)
    );

    assign acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, qbit};

    // Sign correction. With a zero divisor every trial succeeds, so the
    // remainder half ends up holding |srca| and re-signs to the dividend.
    always_comb begin
        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (opnd_q == '0) begin
            quo = {WIDTH{MD_DIV0_QBIT}};
        end
        if (op_q == MD_MULT) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end else begin
            hi_d = rem;
            lo_d = quo;
        end
    end

    // Control FSM, iteration counter and HI/LO writeback.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_DIV;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= CNTW'(WIDTH - 1);
                        op_q    <= operation64;
                        sa_q    <= srca[WIDTH-1];
                        sb_q    <= srcb[WIDTH-1];
                        busy_q  <= 1'b1;
                        if (operation64 == MD_MULT) begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_b};
                            opnd_q <= abs_a;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_a};
                            opnd_q <= abs_b;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= FINISH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, HI/LO hold, signs, corner cases.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        operation64;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec  = 0;
    int errs = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .operation64 (operation64),
        .srca        (srca),
        .srcb        (srcb),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge of the
    // done cycle, so a following call issues start in the done cycle.
    task automatic do_op(input string tag, input logic op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int glitch_n);
        start = 1'b1; operation64 = op; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            chk({tag, " busy/hold"}, {30'd0, busy, done, hi, lo},
                {30'd0, 1'b1, 1'b0, cur_hi, cur_lo});
            if (n == glitch_n) begin
                start = 1'b1; operation64 = 1'b1;
                srca = 32'h55; srcb = 32'h77;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " done"}, {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});
        chk({tag, " hi/lo"}, {hi, lo}, {ehi, elo});
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    task automatic idle();
        @(negedge clk);
        chk("idle", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; operation64 = 1'b0;
        srca = '0; srcb = '0;
        repeat (3) @(negedge clk);
        chk("reset", {30'd0, busy, done, hi, lo}, 64'd0);
        reset = 1'b1;
        idle();

        do_op("mul 7*-3", 1'b1, 32'h7, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        idle();
        do_op("mul min*min", 1'b1, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h0, 0);
        idle();
        do_op("mul -1*-1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h0, 32'h1, 0);
        idle();
        do_op("div 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        idle();
        do_op("div -100/7", 1'b0, 32'hFFFFFF9C, 32'd7,
              32'hFFFFFFFE, 32'hFFFFFFF2, 0);
        idle();
        do_op("div 100/-7", 1'b0, 32'd100, 32'hFFFFFFF9,
              32'd2, 32'hFFFFFFF2, 0);
        idle();
        do_op("div 5/0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0);
        idle();
        do_op("div -5/0", 1'b0, 32'hFFFFFFFB, 32'd0,
              32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        idle();
        do_op("div ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000, 0);
        idle();

        do_op("mul 3*4", 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 0);
        idle();
        do_op("div 9/2 glitch", 1'b0, 32'd9, 32'd2, 32'd1, 32'd4, 5);
        idle();

        do_op("b2b mul 2*3", 1'b1, 32'd2, 32'd3, 32'd0, 32'd6, 0);
        do_op("b2b div 10/3", 1'b0, 32'd10, 32'd3, 32'd1, 32'd3, 0);
        idle();

        start = 1'b1; operation64 = 1'b0; srca = 32'd9; srcb = 32'd2;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 10; n++) @(negedge clk);
        chk("abort busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort state", {30'd0, busy, done, hi, lo}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            chk("abort no done", {62'd0, busy, done}, 64'd0);
        end

        do_op("mul -2*5", 1'b1, 32'hFFFFFFFE, 32'd5,
              32'hFFFFFFFF, 32'hFFFFFFF6, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
